// File: rtl/ccff_chain_loader.sv
// Serial loader for one tile's configuration flip-flop chain: words in over valid/ready, bits out LSB first.
// Optional CCFF_VERIFY_EN adds a CRC-8 recirculating readback pass that flags chain corruption on error.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BIT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN);
  localparam logic [BIT_W-1:0] LAST_WBIT = BIT_W'(WORD_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_SHIFT,
`ifdef CCFF_VERIFY_EN
    ST_VERIFY,
`endif
    ST_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_sreg, w_sreg_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [BIT_W-1:0]  r_word_bits, w_word_bits_nxt;
  logic              r_head, w_head_nxt;
  logic              r_shift_en, w_shift_en_nxt;
  logic              r_word_ready, w_word_ready_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_error, w_error_nxt;

`ifdef CCFF_VERIFY_EN
  logic [7:0] r_crc_s, w_crc_s_nxt;
  logic [7:0] r_crc_v, w_crc_v_nxt;
  logic       r_verify, w_verify_nxt;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? 8'h07 : 8'h00);
  endfunction
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
`endif

  // Next-state, datapath and registered-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_sreg_nxt      = r_sreg;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_word_bits_nxt = r_word_bits;
    w_head_nxt      = 1'b0;
    w_shift_en_nxt  = 1'b0;
    w_done_nxt      = r_done;
    w_error_nxt     = r_error;
`ifdef CCFF_VERIFY_EN
    w_crc_s_nxt     = r_crc_s;
    w_crc_v_nxt     = r_crc_v;
    w_verify_nxt    = 1'b0;
`endif
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt     = ST_WAIT_WORD;
          w_done_nxt      = 1'b0;
          w_error_nxt     = 1'b0;
          w_bit_cnt_nxt   = '0;
          w_word_bits_nxt = '0;
          w_sreg_nxt      = '0;
`ifdef CCFF_VERIFY_EN
          w_crc_s_nxt     = 8'h00;
          w_crc_v_nxt     = 8'h00;
`endif
        end
      end
      ST_WAIT_WORD: begin
        if (word_valid && r_word_ready) begin
          w_state_nxt     = ST_SHIFT;
          w_head_nxt      = word_data[0];
          w_sreg_nxt      = word_data >> 1;
          w_shift_en_nxt  = 1'b1;
          w_bit_cnt_nxt   = r_bit_cnt + CNT_W'(1);
          w_word_bits_nxt = BIT_W'(1);
        end
      end
      ST_SHIFT: begin
`ifdef CCFF_VERIFY_EN
        w_crc_s_nxt = crc8_step(r_crc_s, r_head);
`endif
        // Chain-full check wins so unused upper bits of the last word are dropped
        if (r_bit_cnt == LAST_BIT) begin
`ifdef CCFF_VERIFY_EN
          w_state_nxt    = ST_VERIFY;
          w_shift_en_nxt = 1'b1;
          w_verify_nxt   = 1'b1;
          w_bit_cnt_nxt  = CNT_W'(1);
`else
          w_state_nxt    = ST_DONE;
          w_done_nxt     = 1'b1;
`endif
        end else if (r_word_bits == LAST_WBIT) begin
          w_state_nxt = ST_WAIT_WORD;
        end else begin
          w_head_nxt      = r_sreg[0];
          w_sreg_nxt      = r_sreg >> 1;
          w_shift_en_nxt  = 1'b1;
          w_bit_cnt_nxt   = r_bit_cnt + CNT_W'(1);
          w_word_bits_nxt = r_word_bits + BIT_W'(1);
        end
      end
`ifdef CCFF_VERIFY_EN
      ST_VERIFY: begin
        w_crc_v_nxt = crc8_step(r_crc_v, ccff_tail);
        if (r_bit_cnt == LAST_BIT) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_error_nxt = (w_crc_v_nxt != r_crc_s);
        end else begin
          w_shift_en_nxt = 1'b1;
          w_verify_nxt   = 1'b1;
          w_bit_cnt_nxt  = r_bit_cnt + CNT_W'(1);
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
    w_word_ready_nxt = (w_state_nxt == ST_WAIT_WORD);
    w_busy_nxt       = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_sreg       <= '0;
      r_bit_cnt    <= '0;
      r_word_bits  <= '0;
      r_head       <= 1'b0;
      r_shift_en   <= 1'b0;
      r_word_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef CCFF_VERIFY_EN
      r_crc_s      <= 8'h00;
      r_crc_v      <= 8'h00;
      r_verify     <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_sreg       <= w_sreg_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_word_bits  <= w_word_bits_nxt;
      r_head       <= w_head_nxt;
      r_shift_en   <= w_shift_en_nxt;
      r_word_ready <= w_word_ready_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
`ifdef CCFF_VERIFY_EN
      r_crc_s      <= w_crc_s_nxt;
      r_crc_v      <= w_crc_v_nxt;
      r_verify     <= w_verify_nxt;
`endif
    end
  end

`ifdef CCFF_VERIFY_EN
  // Recirculation must close the loop in the same cycle, so head follows tail directly
  assign ccff_head = r_verify ? ccff_tail : r_head;
`else
  assign ccff_head = r_head;
`endif
  assign ccff_shift_en = r_shift_en;
  assign word_ready    = r_word_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Serial configuration-chain programming controller for a tile's configuration flip-flop chain. It accepts the tile bitstream as parallel words over a valid/ready handshake and shifts it one bit per enabled clock onto the chain head. It sequences load, optional verify and completion, so the chain of `DFF` cells is programmed without host bit-banging. It sits between the fabric configuration port and the `ccff_head`/`ccff_tail` pins of one tile.

## Interface
Parameters:
- `CHAIN_LEN`, 64: number of configuration flip-flops in the chain. Must be at least 1.
- `WORD_W`, 8: bitstream word width. Must be at least 1.

Ports:
- `clk`  in  1  single clock for all state; the chain is clocked by the same `clk`.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a programming sequence. Sampled only in IDLE or DONE.
- `word_valid`  in  1  bitstream word present.
- `word_data`  in  WORD_W  bitstream word. Bit 0 is shifted first.
- `word_ready`  out  1  controller accepts `word_data` this cycle.
- `ccff_head`  out  1  serial data into the chain.
- `ccff_shift_en`  out  1  chain shifts on this rising edge.
- `ccff_tail`  in  1  serial data out of the chain; used only with the verify feature.
- `busy`  out  1  sequence in progress.
- `done`  out  1  sequence complete. Held until the next `start`.
- `error`  out  1  verify mismatch. Valid while `done`=1.

## Operation
- States:
  - IDLE: `start` -> WAIT_WORD.
  - WAIT_WORD: on `word_valid && word_ready` -> SHIFT.
  - SHIFT: once the word's bits are exhausted and the chain is not yet full -> WAIT_WORD. Once CHAIN_LEN bits have been shifted -> VERIFY if the feature is compiled in, else DONE.
  - VERIFY: after CHAIN_LEN cycles -> DONE.
  - DONE: `start` -> WAIT_WORD.
- `word_ready`=1 only in WAIT_WORD, with no combinational dependency on `word_valid`.
- The accepted word loads a WORD_W shift register.
  - In SHIFT, each cycle drives `ccff_head`=sreg[0] with `ccff_shift_en`=1, then shifts the register right.
- Bit counter width is clog2(CHAIN_LEN+1); it counts total bits shifted.
  - Word count = ceil(CHAIN_LEN/WORD_W).
  - Upper unused bits of the final word are discarded, not shifted.
- The first bit shifted ends in the flip-flop nearest `ccff_tail`.
- `busy`=1 in WAIT_WORD, SHIFT and VERIFY.
- `start` while busy is ignored. `start` in DONE clears `done` and `error` and restarts.
- `word_valid` with `word_data` outside WAIT_WORD is ignored and not consumed.
- A stalled `word_valid`=0 in WAIT_WORD holds the state indefinitely. `ccff_shift_en` stays 0, so the chain is frozen.

## Timing
- Reset values: IDLE, `word_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `error`=0, counters and sreg 0.
- `ccff_head` and `ccff_shift_en` are registered. The chain samples `ccff_head` at the rising edge that ends a cycle with `ccff_shift_en`=1.
- `start` at edge N gives `busy`=1 and `word_ready`=1 in cycle N+1.
- Handshake at edge M gives the first shift bit in cycle M+1.
- Minimum sequence time with no stalls: ceil(CHAIN_LEN/WORD_W) handshake cycles + CHAIN_LEN shift cycles (+ CHAIN_LEN verify cycles). The default is 72 cycles to `done`.
- `done` rises the cycle after the last shift or verify cycle.
- Reset asserted mid-sequence returns to IDLE immediately, and `ccff_shift_en` drops asynchronously. Chain contents are then undefined.

## Configuration
- `CCFF_VERIFY_EN` defined:
  - During SHIFT, a CRC-8 (poly 0x07, init 0x00, one bit per shift) accumulates every bit driven on `ccff_head`.
  - VERIFY then runs CHAIN_LEN cycles with `ccff_shift_en`=1 and `ccff_head`=`ccff_tail`, recirculating the chain so contents are restored. A second CRC-8 accumulates `ccff_tail`.
  - At DONE, `error`=1 if the two CRCs differ.
- `CCFF_VERIFY_EN` undefined: no VERIFY state, no CRC logic, `error` tied 0, and `ccff_tail` unused.

## Test plan
- Reset with no traffic: all outputs 0 and `word_ready` stays 0 for 20 cycles. Reset asserted mid-SHIFT: `ccff_shift_en`=0 at once and IDLE outputs follow.
- Default params, `start`, then 8 back-to-back words 0xA5..0xAC: exactly 64 `ccff_shift_en` cycles. The 64-bit model chain matches the LSB-first serialisation, and `done`=1 at cycle 72 (136 with verify).
- CHAIN_LEN=13, WORD_W=8, words 0xFF and 0x1F: 2 handshakes and 13 shifts. `done` asserts, and bits 5..7 of word 2 are never shifted.
- `word_valid` withheld for 10 cycles between words: `ccff_shift_en`=0 and `ccff_head` stable throughout. The result is identical to the no-stall case. `start` pulsed during SHIFT has no effect.
- With `CCFF_VERIFY_EN`, a correct chain model gives `error`=0 and restored contents. With one chain bit forced to flip, `error`=1 at `done`.
- From DONE, `start` clears `done` and `error` and reprograms with new data. The final chain holds only the new bitstream.
